// File: rtl/scroll_msg_display.sv
// Scrolling-message driver for DE-series 7-segment banks: circular glyph buffer,
// sliding window, prescaled auto-scroll, single-step and runtime write port.
// Optional build macro SCROLL_FULL_HEX_EN decodes every non-blank code as a hex digit 0-F.
module scroll_msg_display #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_COUNT = 50_000_000
) (
  input  logic                         CLOCK_50,
  input  logic [0:0]                   KEY,
  input  logic                         run,
  input  logic                         dir,
  input  logic                         step,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
  input  logic [4:0]                   wr_data,
  output logic [7*NUM_DIGITS-1:0]      hex_o,
  output logic [$clog2(MSG_LEN)-1:0]   pos_o,
  output logic                         tick_o
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int PW = $clog2(TICK_COUNT);
  localparam logic [AW-1:0] OFF_RST  = AW'(MSG_LEN - NUM_DIGITS);
  localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_COUNT - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] off_q, off_d;
  logic          tick_q;
  logic          adv;
  logic          wr_ok;
  logic [4:0]    msg_q [MSG_LEN];
  int            idx;

  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] s;
    s = 7'h7F;
    if (!code[4]) begin
`ifdef SCROLL_FULL_HEX_EN
      case (code[3:0])
        4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
        4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
        4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
        4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
`else
      case (code[3:0])
        4'h1:    s = 7'h79;
        4'hD:    s = 7'h21;
        4'hE:    s = 7'h06;
        default: s = 7'h7F;
      endcase
`endif
    end
    return s;
  endfunction

  // Addresses past the end of a non-power-of-two buffer are silently dropped.
  assign wr_ok = wr_en && (int'(wr_addr) < MSG_LEN);

  always_comb begin
    presc_d = presc_q;
    adv     = 1'b0;
    if (run) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        adv     = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (step) begin
      adv = 1'b1;
    end

    off_d = off_q;
    if (adv) begin
      if (dir) off_d = (off_q == '0) ? OFF_LAST : off_q - 1'b1;
      else     off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      presc_q <= '0;
      off_q   <= OFF_RST;
      tick_q  <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        if (i == MSG_LEN - 3)      msg_q[i] <= 5'h0D;
        else if (i == MSG_LEN - 2) msg_q[i] <= 5'h0E;
        else if (i == MSG_LEN - 1) msg_q[i] <= 5'h01;
        else                       msg_q[i] <= 5'h10;
      end
    end else begin
      presc_q <= presc_d;
      off_q   <= off_d;
      tick_q  <= adv;
      if (wr_ok) msg_q[wr_addr] <= wr_data;
    end
  end

  // Leftmost digit (index NUM_DIGITS-1) shows the entry at the window offset.
  always_comb begin
    hex_o = '1;
    idx   = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      idx = int'(off_q) + NUM_DIGITS - 1 - k;
      if (idx >= MSG_LEN) idx = idx - MSG_LEN;
      hex_o[7*k +: 7] = seg_decode(msg_q[AW'(idx)]);
    end
  end

  assign pos_o  = off_q;
  assign tick_o = tick_q;

endmodule
